frequency_generator: RTL

- Programmable square-wave / burst generator. It is the transmit-side counterpart of frequency_counter.
- Drives a known-frequency signal onto an IO pad so the counter can be exercised in loopback on silicon.
- Configured through logic-analyzer bits via a load strobe, in the same way as the counter's period_load/period.
- Sits inside the project wrapper alongside frequency_counter.

---
 rtl/freq_gen_pkg.sv | 14 +
 rtl/frequency_generator.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/freq_gen_pkg.sv
// Shared definitions for frequency_generator: phase state encoding and
// default counter widths.
package freq_gen_pkg;

    localparam int unsigned DEFAULT_WIDTH       = 16;
    localparam int unsigned DEFAULT_BURST_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/frequency_generator.sv
// Programmable square-wave / burst generator.
// Emits `burst` full cycles (0 = continuous) of a square wave whose phases
// each last `period` enabled clk cycles. Output frequency = f_clk/(2*period).
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   period_load  one-cycle strobe; captures period/burst (and high_period)
//   period       half-period in clk cycles (0 on load = stop, go idle)
//   burst        number of full output cycles; 0 = continuous
//   enable       low pauses generation (state and counters hold)
//   high_period  (only with FREQ_GEN_DUTY_EN) HIGH phase length; 0 = period
//   signal       registered square-wave output
//   running      high while in HIGH or LOW
//   done         one-cycle pulse when a finite burst completes
//
// Build option: define FREQ_GEN_DUTY_EN to add the high_period input for
// non-50% duty cycle. Without it both phases last `period` cycles.
module frequency_generator
    import freq_gen_pkg::*;
#(
    parameter int unsigned WIDTH       = DEFAULT_WIDTH,
    parameter int unsigned BURST_WIDTH = DEFAULT_BURST_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   period_load,
    input  logic [WIDTH-1:0]       period,
    input  logic [BURST_WIDTH-1:0] burst,
    input  logic                   enable,
`ifdef FREQ_GEN_DUTY_EN
    input  logic [WIDTH-1:0]       high_period,
`endif
    output logic                   signal,
    output logic                   running,
    output logic                   done
);

    state_t                 state, state_d;
    logic [WIDTH-1:0]       cnt, cnt_d;
    logic [BURST_WIDTH-1:0] rem, rem_d;
    logic [WIDTH-1:0]       period_q, period_d;
    logic [BURST_WIDTH-1:0] burst_q, burst_d;
    logic                   done_d;
    logic                   signal_d;
    logic                   running_d;

    // HIGH phase length for the captured config and for a config being loaded
    logic [WIDTH-1:0]       high_len;
    logic [WIDTH-1:0]       load_high_len;

`ifdef FREQ_GEN_DUTY_EN
    logic [WIDTH-1:0]       high_q, high_d;

    assign high_len      = (high_q != '0) ? high_q : period_q;
    assign load_high_len = (high_period != '0) ? high_period : period;
`else
    assign high_len      = period_q;
    assign load_high_len = period;
`endif

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rem      <= '0;
            period_q <= '0;
            burst_q  <= '0;
`ifdef FREQ_GEN_DUTY_EN
            high_q   <= '0;
`endif
            signal   <= 1'b0;
            running  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            rem      <= rem_d;
            period_q <= period_d;
            burst_q  <= burst_d;
`ifdef FREQ_GEN_DUTY_EN
            high_q   <= high_d;
`endif
            signal   <= signal_d;
            running  <= running_d;
            done     <= done_d;
        end
    end

    // Next-state logic; a load overrides every other event in its cycle
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        rem_d    = rem;
        period_d = period_q;
        burst_d  = burst_q;
`ifdef FREQ_GEN_DUTY_EN
        high_d   = high_q;
`endif
        done_d   = 1'b0;

        if (period_load) begin
            if (period != '0) begin
                period_d = period;
                burst_d  = burst;
                rem_d    = burst;
`ifdef FREQ_GEN_DUTY_EN
                high_d   = high_period;
`endif
                cnt_d    = load_high_len - WIDTH'(1);
                state_d  = ST_HIGH;
            end else begin
                // Zero period stops generation; the strobe's values are dropped
                cnt_d    = '0;
                state_d  = ST_IDLE;
            end
        end else if (enable) begin
            unique case (state)
                ST_HIGH: begin
                    if (cnt != '0) begin
                        cnt_d = cnt - WIDTH'(1);
                    end else begin
                        cnt_d   = period_q - WIDTH'(1);
                        state_d = ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (cnt != '0) begin
                        cnt_d = cnt - WIDTH'(1);
                    end else if (burst_q == '0) begin
                        cnt_d   = high_len - WIDTH'(1);
                        state_d = ST_HIGH;
                    end else if (rem == BURST_WIDTH'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rem_d   = rem - BURST_WIDTH'(1);
                        cnt_d   = high_len - WIDTH'(1);
                        state_d = ST_HIGH;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output decode from the next state so the outputs change on the same edge
    always_comb begin
        signal_d  = (state_d == ST_HIGH);
        running_d = (state_d != ST_IDLE);
    end

endmodule
